song_sequencer: RTL
===================

Name: song_sequencer

Overview:
- Upstream stage of the note-sound block.
- Walks a song stored in an external synchronous ROM, decodes each 16-bit entry into octave/note/length/full_note, and drives the sound stage's enable.
- Advances to the next entry when the sound stage reports the note finished, after a fixed silent gap.
- Supports start, stop, loop and rest entries.

Parameters:
- ADDR_W, 8, ROM address width.
- GAP_CYCLES, 5000000, silent inter-note gap in clk cycles (50 ms at 100 MHz); minimum 1.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin playback at song_base (single-cycle pulse)
- stop  in  1  abort playback (level or pulse)
- loop_en  in  1  restart at song_base on end-of-song entry
- song_base  in  ADDR_W  first entry address, sampled on accepted start
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  16  ROM word, valid one cycle after rom_addr
- octave  out  3  to sound stage
- note  out  3  to sound stage
- length  out  4  to sound stage (note value exponent)
- full_note  out  3  to sound stage (whole-note multiplier, seconds)
- snd_en  out  1  sound stage enable
- snd_over  in  1  sound stage note-finished level; the sound stage clears it while snd_en is low
- mute  out  1  high during rest entries; top level gates the buzzer with it
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at natural song end

Behaviour:
- ROM entry format:
  - [15:13] octave
  - [12:10] note
  - [9:6] length
  - [5:3] full_note
  - [2] rest
  - [1] end
  - [0] reserved, ignored
- Reset values: rom_addr=0, octave/note/length/full_note=0, snd_en=0, mute=0, busy=0, done=0, state IDLE. All outputs are registered.
- States: IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- IDLE:
  - On start=1 and stop=0, latch song_base into the address register, clear played_any, go to FETCH.
  - start while busy is ignored.
- FETCH: rom_addr = address register; one cycle; go to LOAD.
- LOAD: capture rom_data.
  - end=1:
    - loop_en=1 and played_any=1: address = song_base (latched), go to FETCH.
    - Otherwise go to DONE. An empty song with loop_en never spins.
  - full_note=0: skip the entry; address+1, go to FETCH; snd_en stays 0.
  - Otherwise:
    - Register the fields.
    - Clamp length>6 to 6.
    - mute = rest | (note==7).
    - Set played_any, go to PLAY with snd_en=1 from the next cycle.
- PLAY:
  - snd_en=1; fields held stable.
  - snd_over is ignored in the first PLAY cycle (stale level). From the second cycle, snd_over=1 moves to GAP.
- GAP:
  - snd_en=0, mute=0.
  - Counter runs 0..GAP_CYCLES-1, then address+1 and go to FETCH.
- Address increment wraps from 2^ADDR_W-1 to 0.
- DONE: done=1 for exactly one cycle, snd_en=0, then IDLE. busy=1 in DONE.
- stop=1 in any non-IDLE state:
  - Next cycle IDLE, snd_en=0, mute=0, gap counter cleared, no done pulse.
  - stop with start in the same cycle: stop wins, remain IDLE.
- Latency: start to snd_en=1 is 3 cycles (FETCH, LOAD, PLAY entry).
- The gap counter is wide enough for GAP_CYCLES: a 32-bit register.
- Reset asserted mid-note: all outputs return to reset values asynchronously; no partial done.

Test Plan:
- Entries at 0: {oct 4, note 0, len 2, full 1}; at 1: end. start, base=0 → rom_addr=0; snd_en rises 3 cycles after start. octave=4, note=0, length=2, full_note=1 held until snd_over; then gap of GAP_CYCLES (set 10 in bench), done pulse, busy falls.
- Rest entry (rest=1, note=3) followed by note=7 entry → mute=1 with snd_en=1 for both; mute=0 in GAP.
- loop_en=1 with 2-note song, base=0x10 → after end entry, rom_addr returns to 0x10; three full passes observed, no done. stop mid-PLAY → snd_en=0 next cycle, IDLE, no done.
- Empty song (base entry end=1, loop_en=1) → DONE after LOAD, done pulse, no snd_en activity. full_note=0 entry → skipped, rom_addr increments without snd_en.
- length=9 entry → length output 6. Entry at address 0xFF (ADDR_W=8) → next fetch at 0x00.
- start and stop asserted together in IDLE → remains IDLE. snd_over held 1 at PLAY entry → first PLAY cycle ignores it, GAP entered on cycle 2. rst_n pulled low during GAP → outputs zero immediately.

Source files
------------

// File: rtl/song_sequencer.sv
// Song sequencer: walks a song held in an external synchronous ROM, decodes each entry
// and hands octave/note/length/full_note to the sound stage with an inter-note gap.
module song_sequencer #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned GAP_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] song_base,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [2:0]        octave,
  output logic [2:0]        note,
  output logic [3:0]        length,
  output logic [2:0]        full_note,
  output logic              snd_en,
  input  logic              snd_over,
  output logic              mute,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0] LEN_MAX = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_d, base_q, base_d;
  logic              played_q, played_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic [2:0]        octave_d, note_d, full_note_d;
  logic [3:0]        length_d;
  logic              snd_en_d, mute_d, busy_d, done_d;

  // ROM entry fields
  logic [2:0] e_oct, e_note, e_full;
  logic [3:0] e_len;
  logic       e_rest, e_end;
  logic       rom_data_unused;

  assign e_oct           = rom_data[15:13];
  assign e_note          = rom_data[12:10];
  assign e_len           = rom_data[9:6];
  assign e_full          = rom_data[5:3];
  assign e_rest          = rom_data[2];
  assign e_end           = rom_data[1];
  assign rom_data_unused = rom_data[0];

  // State and output registers; rom_addr doubles as the entry address register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rom_addr  <= '0;
      base_q    <= '0;
      played_q  <= 1'b0;
      first_q   <= 1'b0;
      gap_q     <= '0;
      octave    <= '0;
      note      <= '0;
      length    <= '0;
      full_note <= '0;
      snd_en    <= 1'b0;
      mute      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rom_addr  <= addr_d;
      base_q    <= base_d;
      played_q  <= played_d;
      first_q   <= first_d;
      gap_q     <= gap_d;
      octave    <= octave_d;
      note      <= note_d;
      length    <= length_d;
      full_note <= full_note_d;
      snd_en    <= snd_en_d;
      mute      <= mute_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = rom_addr;
    base_d      = base_q;
    played_d    = played_q;
    first_d     = first_q;
    gap_d       = gap_q;
    octave_d    = octave;
    note_d      = note;
    length_d    = length;
    full_note_d = full_note;
    snd_en_d    = snd_en;
    mute_d      = mute;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          addr_d   = song_base;
          base_d   = song_base;
          played_d = 1'b0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (e_end) begin
          // A song with no playable entry must not loop forever
          if (loop_en && played_q) begin
            addr_d  = base_q;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else if (e_full == 3'd0) begin
          addr_d  = rom_addr + ADDR_W'(1);
          state_d = S_FETCH;
        end else begin
          octave_d    = e_oct;
          note_d      = e_note;
          length_d    = (e_len > LEN_MAX) ? LEN_MAX : e_len;
          full_note_d = e_full;
          mute_d      = e_rest | (e_note == 3'd7);
          played_d    = 1'b1;
          first_d     = 1'b1;
          snd_en_d    = 1'b1;
          state_d     = S_PLAY;
        end
      end
      S_PLAY: begin
        // snd_over may still be high from the previous note during the first cycle
        first_d = 1'b0;
        if (!first_q && snd_over) begin
          snd_en_d = 1'b0;
          mute_d   = 1'b0;
          gap_d    = '0;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          addr_d  = rom_addr + ADDR_W'(1);
          state_d = S_FETCH;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (stop && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      snd_en_d = 1'b0;
      mute_d   = 1'b0;
      gap_d    = '0;
      done_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule
